fde_unit: RTL and testbench

FDE_UNIT -- requirements
Module: fde_unit

---
 rtl/fde_pkg.sv | 129 ++++++++++++
 rtl/fde_alu.sv | 51 +++++
 rtl/fde_unit.sv | 158 +++++++++++++++
 tb/tb_fde_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fde_pkg.sv
// Shared types for the fetch/decode/execute unit: RV32I opcodes, ALU ops,
// FSM states, the decoded-instruction record and the decode function.
// Optional macro FDE_MUL_EN: when defined, OP/funct7=0000001/funct3=0 (MUL) is legal.
package fde_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH_REQ, ST_FETCH_WAIT, ST_DECODE, ST_EXEC, ST_DONE
    } state_e;

    // Instruction class selects how result / jump_dest are formed in EXEC.
    typedef enum logic [2:0] {
        CLS_NONE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_MEM, CLS_ALU
    } cls_e;

    typedef struct packed {
        cls_e        cls;
        alu_op_e     alu_op;
        logic        use_imm;
        logic [31:0] imm;
        logic        is_load;
        logic        is_store;
        logic        reg_write;
        logic        illegal;
    } dec_t;

    // Register-register / register-immediate ALU op selection from funct3.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        case (f3)
            3'd0:    f3_to_op = ALU_ADD;
            3'd1:    f3_to_op = ALU_SLL;
            3'd2:    f3_to_op = ALU_SLT;
            3'd3:    f3_to_op = ALU_SLTU;
            3'd4:    f3_to_op = ALU_XOR;
            3'd5:    f3_to_op = ALU_SRL;
            3'd6:    f3_to_op = ALU_OR;
            default: f3_to_op = ALU_AND;
        endcase
    endfunction

    function automatic dec_t fde_decode(input logic [31:0] ins);
        dec_t        d;
        logic        ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d     = '0;
        ok    = 1'b1;
        case (ins[6:0])
            OPC_LUI:   begin d.cls = CLS_LUI;   d.imm = imm_u; d.reg_write = 1'b1; end
            OPC_AUIPC: begin d.cls = CLS_AUIPC; d.imm = imm_u; d.reg_write = 1'b1; end
            OPC_JAL:   begin d.cls = CLS_JAL;   d.imm = imm_j; d.reg_write = 1'b1; end
            OPC_JALR: begin
                d.cls = CLS_JALR; d.imm = imm_i; d.use_imm = 1'b1; d.reg_write = 1'b1;
                ok = (f3 == 3'd0);
            end
            OPC_BRANCH: begin
                d.cls = CLS_BRANCH; d.imm = imm_b;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OPC_LOAD: begin
                d.cls = CLS_MEM; d.imm = imm_i; d.use_imm = 1'b1;
                d.is_load = 1'b1; d.reg_write = 1'b1;
                ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            OPC_STORE: begin
                d.cls = CLS_MEM; d.imm = imm_s; d.use_imm = 1'b1; d.is_store = 1'b1;
                ok = (f3 <= 3'd2);
            end
            OPC_OPIMM: begin
                d.cls = CLS_ALU; d.imm = imm_i; d.use_imm = 1'b1; d.reg_write = 1'b1;
                d.alu_op = f3_to_op(f3);
                // Shift-immediates reuse the funct7 field; only SRAI may set bit 30.
                if (f3 == 3'd1) ok = (f7 == 7'b0000000);
                if (f3 == 3'd5) begin
                    if (f7 == 7'b0100000)      d.alu_op = ALU_SRA;
                    else if (f7 != 7'b0000000) ok = 1'b0;
                end
            end
            OPC_OP: begin
                d.cls = CLS_ALU; d.reg_write = 1'b1;
                d.alu_op = f3_to_op(f3);
                if (f7 == 7'b0000000) begin
                    ok = 1'b1;
                end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
                    d.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
                    d.alu_op = ALU_SRA;
`ifdef FDE_MUL_EN
                end else if (f7 == 7'b0000001 && f3 == 3'd0) begin
                    d.alu_op = ALU_MUL;
`endif
                end else begin
                    ok = 1'b0;
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        // Writes to x0 are architecturally discarded.
        if (ins[11:7] == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/fde_alu.sv
// Combinational ALU plus branch comparator for fde_unit.
// Ports: alu_op_i/a_i/b_i -> y_o; br_funct3_i/rs1_i/rs2_i -> br_taken_o.
// Optional macro FDE_MUL_EN enables the low-word multiply op.
module fde_alu
    import fde_pkg::*;
(
    input  alu_op_e     alu_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  br_funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] y_o,
    output logic        br_taken_o
);
    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        y_o = '0;
        case (alu_op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: y_o = {31'b0, a_i < b_i};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
`ifdef FDE_MUL_EN
            ALU_MUL:  y_o = a_i * b_i;
`endif
            default:  y_o = '0;
        endcase
    end

    always_comb begin
        br_taken_o = 1'b0;
        case (br_funct3_i)
            3'd0:    br_taken_o = (rs1_i == rs2_i);
            3'd1:    br_taken_o = (rs1_i != rs2_i);
            3'd4:    br_taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            3'd5:    br_taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            3'd6:    br_taken_o = (rs1_i <  rs2_i);
            3'd7:    br_taken_o = (rs1_i >= rs2_i);
            default: br_taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/fde_unit.sv
// Single-issue RV32I fetch/decode/execute pass: fetch bus (request/response),
// register-file read ports (data one cycle after address) and registered results.
// Ports: start/pc in, done pulse out; done lands 3 cycles after the response.
// Optional macro FDE_MUL_EN (via fde_pkg / fde_alu) adds MUL.
module fde_unit
    import fde_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic [31:0] pc,
    output logic        request_enable,
    output logic        mode,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        response_enable,
    input  logic [31:0] data,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] pc_out,
    output logic [31:0] instr_raw,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        reg_write,
    output logic        is_load,
    output logic        is_store,
    output logic [31:0] store_data,
    output logic [31:0] result,
    output logic        is_jump_chosen,
    output logic [31:0] jump_dest,
    output logic        illegal
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, instr_q;
    dec_t        dec_q;
    logic [31:0] pc_out_q, store_data_q, result_q, jump_dest_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic        reg_write_q, is_load_q, is_store_q, jump_q, illegal_q;

    logic [31:0] alu_y, result_d, jump_dest_d, pc_plus4, pc_imm;
    logic        br_taken, jump_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start) state_d = ST_FETCH_REQ;
            ST_FETCH_REQ:  state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (response_enable) state_d = ST_DECODE;
            ST_DECODE:     state_d = ST_EXEC;
            ST_EXEC:       state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    fde_alu u_alu (
        .alu_op_i    (dec_q.alu_op),
        .a_i         (rs1_data),
        .b_i         (dec_q.use_imm ? dec_q.imm : rs2_data),
        .br_funct3_i (instr_q[14:12]),
        .rs1_i       (rs1_data),
        .rs2_i       (rs2_data),
        .y_o         (alu_y),
        .br_taken_o  (br_taken)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_imm   = pc_q + dec_q.imm;

    always_comb begin
        result_d    = alu_y;
        jump_d      = 1'b0;
        jump_dest_d = pc_plus4;
        case (dec_q.cls)
            CLS_LUI:    result_d = dec_q.imm;
            CLS_AUIPC:  result_d = pc_imm;
            CLS_JAL: begin
                result_d = pc_plus4; jump_d = 1'b1; jump_dest_d = pc_imm;
            end
            CLS_JALR: begin
                result_d = pc_plus4; jump_d = 1'b1; jump_dest_d = {alu_y[31:1], 1'b0};
            end
            CLS_BRANCH: begin
                result_d = '0; jump_d = br_taken;
                jump_dest_d = br_taken ? pc_imm : pc_plus4;
            end
            CLS_MEM, CLS_ALU: result_d = alu_y;
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            instr_q      <= '0;
            dec_q        <= '0;
            pc_out_q     <= RESET_PC;
            rd_q         <= '0;
            funct3_q     <= '0;
            reg_write_q  <= 1'b0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            store_data_q <= '0;
            result_q     <= '0;
            jump_q       <= 1'b0;
            jump_dest_q  <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) pc_q <= pc;
            if (state_q == ST_FETCH_WAIT && response_enable) instr_q <= data;
            if (state_q == ST_DECODE) dec_q <= fde_decode(instr_q);
            // Register-file data for the addresses shown in DECODE is valid now.
            if (state_q == ST_EXEC) begin
                pc_out_q     <= pc_q;
                rd_q         <= instr_q[11:7];
                funct3_q     <= instr_q[14:12];
                reg_write_q  <= dec_q.reg_write;
                is_load_q    <= dec_q.is_load;
                is_store_q   <= dec_q.is_store;
                store_data_q <= rs2_data;
                result_q     <= result_d;
                jump_q       <= jump_d;
                jump_dest_q  <= jump_dest_d;
                illegal_q    <= dec_q.illegal;
            end
        end
    end

    assign request_enable = (state_q == ST_FETCH_REQ);
    assign done           = (state_q == ST_DONE);
    assign mode           = 1'b0;
    assign addr           = pc_q;
    assign wdata          = '0;
    assign wstrb          = '0;
    assign rs1_addr       = instr_q[19:15];
    assign rs2_addr       = instr_q[24:20];
    assign pc_out         = pc_out_q;
    assign instr_raw      = instr_q;
    assign rd             = rd_q;
    assign funct3         = funct3_q;
    assign reg_write      = reg_write_q;
    assign is_load        = is_load_q;
    assign is_store       = is_store_q;
    assign store_data     = store_data_q;
    assign result         = result_q;
    assign is_jump_chosen = jump_q;
    assign jump_dest      = jump_dest_q;
    assign illegal        = illegal_q;
endmodule

// File: tb/tb_fde_unit.sv
// Scoreboard bench for fde_unit: directed instructions with hand-computed
// expectations, a register-file model with one-cycle read latency, and a
// monitor that checks every done pulse against the queued expectation.
module tb_fde_unit;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst, start, response_enable;
    logic [31:0] pc, data, rs1_data, rs2_data;
    logic        done, request_enable, mode, reg_write, is_load, is_store, is_jump_chosen, illegal;
    logic [31:0] addr, wdata, pc_out, instr_raw, store_data, result, jump_dest;
    logic [3:0]  wstrb;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [2:0]  funct3;

    always #5 clk = ~clk;

    fde_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .pc(pc),
        .request_enable(request_enable), .mode(mode), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .response_enable(response_enable), .data(data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc_out(pc_out), .instr_raw(instr_raw), .rd(rd), .funct3(funct3), .reg_write(reg_write),
        .is_load(is_load), .is_store(is_store), .store_data(store_data), .result(result),
        .is_jump_chosen(is_jump_chosen), .jump_dest(jump_dest), .illegal(illegal)
    );

    // Register file: data for an address appears one cycle later.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        rs1_data <= regs[rs1_addr];
        rs2_data <= regs[rs2_addr];
    end

    typedef struct {
        logic [31:0] pc_out, instr, result, jdest, sd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, ld, st, jump, ill, chk_res, chk_jd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, ins, res, jd, sd, input logic [4:0] r,
                                input logic [2:0] f, input logic rw, ld, st, j, il, cr, cj);
        exp_t e;
        e.pc_out = p; e.instr = ins; e.result = res; e.jdest = jd; e.sd = sd;
        e.rd = r; e.f3 = f; e.rw = rw; e.ld = ld; e.st = st; e.jump = j; e.ill = il;
        e.chk_res = cr; e.chk_jd = cj;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no transaction pending");
            end else begin
                mon_e = sb.pop_front();
                chk("latency", cyc - resp_cyc, 32'd3);
                chk("pc_out", pc_out, mon_e.pc_out);
                chk("instr_raw", instr_raw, mon_e.instr);
                chk("rd", {27'b0, rd}, {27'b0, mon_e.rd});
                chk("funct3", {29'b0, funct3}, {29'b0, mon_e.f3});
                chk("reg_write", {31'b0, reg_write}, {31'b0, mon_e.rw});
                chk("is_load", {31'b0, is_load}, {31'b0, mon_e.ld});
                chk("is_store", {31'b0, is_store}, {31'b0, mon_e.st});
                chk("is_jump_chosen", {31'b0, is_jump_chosen}, {31'b0, mon_e.jump});
                chk("illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
                chk("store_data", store_data, mon_e.sd);
                chk("bus_static", {mode, wstrb, wdata[26:0]}, 32'h0);
                if (mon_e.chk_res) chk("result", result, mon_e.result);
                if (mon_e.chk_jd)  chk("jump_dest", jump_dest, mon_e.jdest);
            end
        end
    end

    task automatic clr_regs();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    endtask

    // Called at a negedge with the FSM idle.
    task automatic run(input logic [31:0] p, input logic [31:0] ins, input exp_t e);
        int n;
        sb.push_back(e);
        pc = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("req_en", {31'b0, request_enable}, 32'd1);
        chk("addr", addr, p);
        @(negedge clk);
        chk("req_pulse", {31'b0, request_enable}, 32'd0);
        @(negedge clk);
        chk("addr_hold", addr, p);
        response_enable = 1'b1; data = ins; resp_cyc = cyc;
        @(negedge clk);
        response_enable = 1'b0; data = 32'h0;
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 10 cycles");
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int seen_req, seen_done;
        rst = 1'b1; start = 1'b0; response_enable = 1'b0; pc = '0; data = '0;
        clr_regs();
        repeat (2) @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, request_enable}, 32'd0);
        chk("rst_pc_out", pc_out, TB_RESET_PC);
        chk("rst_result", result, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_flags", {27'b0, illegal, reg_write, is_jump_chosen, is_load, is_store}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // addi x1,x0,5
        clr_regs();
        run(32'h0, 32'h00500093, mk(32'h0, 32'h00500093, 32'd5, 32'h4, 32'h0, 5'd1, 3'd0, 1, 0, 0, 0, 0, 1, 1));
        // beq x1,x2,8 taken / not taken
        clr_regs(); regs[1] = 32'd7; regs[2] = 32'd7;
        run(32'h100, 32'h00208463, mk(32'h100, 32'h00208463, 32'h0, 32'h108, 32'd7, 5'd8, 3'd0, 0, 0, 0, 1, 0, 0, 1));
        regs[2] = 32'd8;
        run(32'h100, 32'h00208463, mk(32'h100, 32'h00208463, 32'h0, 32'h104, 32'd8, 5'd8, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        // jalr x1,0(x1)
        clr_regs(); regs[1] = 32'h203;
        run(32'h40, 32'h000080E7, mk(32'h40, 32'h000080E7, 32'h44, 32'h202, 32'h0, 5'd1, 3'd0, 1, 0, 0, 1, 0, 1, 1));
        // all-ones word is not a valid opcode
        clr_regs();
        run(32'h10, 32'hFFFFFFFF, mk(32'h10, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 5'd31, 3'd7, 0, 0, 0, 0, 1, 0, 0));
        // mul x1,x1,x2
        clr_regs(); regs[1] = 32'hFFFFFFFF; regs[2] = 32'd3;
`ifdef FDE_MUL_EN
        run(32'h20, 32'h022080B3, mk(32'h20, 32'h022080B3, 32'hFFFFFFFD, 32'h24, 32'd3, 5'd1, 3'd0, 1, 0, 0, 0, 0, 1, 1));
`else
        run(32'h20, 32'h022080B3, mk(32'h20, 32'h022080B3, 32'h0, 32'h0, 32'd3, 5'd1, 3'd0, 0, 0, 0, 0, 1, 0, 0));
`endif
        // lui x5,0x12345
        clr_regs();
        run(32'h30, 32'h123452B7, mk(32'h30, 32'h123452B7, 32'h12345000, 32'h34, 32'h0, 5'd5, 3'd5, 1, 0, 0, 0, 0, 1, 1));
        // sw x2,8(x1)
        clr_regs(); regs[1] = 32'h1000; regs[2] = 32'hDEADBEEF;
        run(32'h50, 32'h0020A423, mk(32'h50, 32'h0020A423, 32'h1008, 32'h54, 32'hDEADBEEF, 5'd8, 3'd2, 0, 0, 1, 0, 0, 1, 1));
        // lw x3,-4(x1)
        clr_regs(); regs[1] = 32'h1000;
        run(32'h60, 32'hFFC0A183, mk(32'h60, 32'hFFC0A183, 32'hFFC, 32'h64, 32'h0, 5'd3, 3'd2, 1, 1, 0, 0, 0, 1, 1));
        // sra x4,x1,x2 (shift amount = low 5 bits of 0x24 = 4)
        clr_regs(); regs[1] = 32'h80000000; regs[2] = 32'h24;
        run(32'h70, 32'h4020D233, mk(32'h70, 32'h4020D233, 32'hF8000000, 32'h74, 32'h24, 5'd4, 3'd5, 1, 0, 0, 0, 0, 1, 1));
        // slt / sltu x5,x1,x2 with -1 vs 1
        clr_regs(); regs[1] = 32'hFFFFFFFF; regs[2] = 32'd1;
        run(32'h80, 32'h0020A2B3, mk(32'h80, 32'h0020A2B3, 32'd1, 32'h84, 32'd1, 5'd5, 3'd2, 1, 0, 0, 0, 0, 1, 1));
        run(32'h90, 32'h0020B2B3, mk(32'h90, 32'h0020B2B3, 32'd0, 32'h94, 32'd1, 5'd5, 3'd3, 1, 0, 0, 0, 0, 1, 1));
        // addi x0,x0,1: rd = 0 suppresses reg_write
        clr_regs();
        run(32'hA0, 32'h00100013, mk(32'hA0, 32'h00100013, 32'd1, 32'hA4, 32'h0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 1, 1));
        // jal x1,16
        clr_regs();
        run(32'h200, 32'h010000EF, mk(32'h200, 32'h010000EF, 32'h204, 32'h210, 32'h0, 5'd1, 3'd0, 1, 0, 0, 1, 0, 1, 1));
        // bltu x1,x2,-4 (unsigned: taken; signed would not be)
        clr_regs(); regs[1] = 32'd1; regs[2] = 32'hFFFFFFFF;
        run(32'h300, 32'hFE20EEE3, mk(32'h300, 32'hFE20EEE3, 32'h0, 32'h2FC, 32'hFFFFFFFF, 5'd29, 3'd6, 0, 0, 0, 1, 0, 0, 1));

        // Reset while waiting for the fetch response; the late response is ignored.
        clr_regs();
        pc = 32'h500; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        response_enable = 1'b1; data = 32'h00500093;
        @(negedge clk);
        response_enable = 1'b0; data = 32'h0;
        seen_req = 0; seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (request_enable) seen_req = 1;
            if (done) seen_done = 1;
            @(negedge clk);
        end
        chk("rst_mid_done", seen_done, 32'd0);
        chk("rst_mid_req", seen_req, 32'd0);
        chk("rst_mid_pc_out", pc_out, TB_RESET_PC);
        chk("rst_mid_instr", instr_raw, 32'h0);

        // Recovery after the mid-fetch reset.
        clr_regs();
        run(32'h8, 32'h00500093, mk(32'h8, 32'h00500093, 32'd5, 32'hC, 32'h0, 5'd1, 3'd0, 1, 0, 0, 0, 0, 1, 1));

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
